vga_tile_arbiter: RTL and testbench

- Shares one single-port tile RAM (40x30 tiles, 2-bit code per tile) between two requesters: the VGA scan-out path and the snake game logic.
- Sits between the VGA timing generator (hcount/vcount/pix_ce) and the tile RAM.
- Prefetches each 16x16 tile's code ahead of the beam and presents it as tile_code at the tile boundary.
- Game logic reads and writes tiles (moves, collision checks, food placement) through a req/ack handshake in the remaining slots.

---
 rtl/vga_tile_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_vga_tile_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_arbiter.sv
// -----------------------------------------------------------------------------
// vga_tile_arbiter
//
// Shares one single-port tile RAM (COLS x ROWS tiles, DATA_W-bit code each)
// between the VGA scan-out path and the game logic.
//
// Video side: the code of the next 16x16 tile is prefetched a few pixels
// before the beam reaches it. It is moved into tile_code on the last pixel of
// the current tile, so tile_code stays valid for all pixels of the new tile.
// Game side: single-beat reads and writes use a req/ack handshake and run in
// the slots the video fetches leave free. Video always wins a tie.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pix_ce              one-clk pixel enable (at least 4 clk apart)
//   hcount, vcount      beam position from the timing generator
//   tile_code           tile code for the tile under the beam
//   gm_req/gm_we        game request, 1 = write
//   gm_addr/gm_wdata    game tile address (row*COLS+col) and write data
//   gm_ack              one-clk completion pulse
//   gm_rdata            read data, valid while gm_ack=1, held afterwards
//   ram_addr/ram_we     tile RAM address and write enable
//   ram_wdata           tile RAM write data
//   ram_rdata           tile RAM read data, one clk after the address
//   vid_underrun        sticky flag, only with TILE_ARB_UNDERRUN_EN
//
// Optional feature macro: TILE_ARB_UNDERRUN_EN. When it is defined, this adds
// the vid_underrun output. The flag is set when a tile load finds its fetch
// still pending. It is cleared only by rst_n.
// -----------------------------------------------------------------------------
module vga_tile_arbiter #(
   parameter int TILE_BITS = 4,
   parameter int COLS      = 40,
   parameter int ROWS      = 30,
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_TOTAL   = 800,
   parameter int V_TOTAL   = 525
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_ce,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   output logic [DATA_W-1:0] tile_code,
   input  logic              gm_req,
   input  logic              gm_we,
   input  logic [ADDR_W-1:0] gm_addr,
   input  logic [DATA_W-1:0] gm_wdata,
   output logic              gm_ack,
   output logic [DATA_W-1:0] gm_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef TILE_ARB_UNDERRUN_EN
   ,
   output logic              vid_underrun
`endif
);

   localparam int TILE = 1 << TILE_BITS;

   localparam logic [TILE_BITS-1:0] PIX_TRIG = TILE_BITS'(TILE - 4);
   localparam logic [TILE_BITS-1:0] PIX_LAST = TILE_BITS'(TILE - 1);
   localparam logic [9:0]           H_MID_LIM = 10'(H_VISIBLE - 4);
   localparam logic [9:0]           H_EOL_TRIG = 10'(H_TOTAL - 4);
   localparam logic [9:0]           H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]           V_LAST = 10'(V_TOTAL - 1);

   // The whole tile map must be addressable.
   if (COLS * ROWS > (1 << ADDR_W)) begin : g_addr_check
      $error("ADDR_W is too narrow for COLS*ROWS tiles");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_VID_RD,
      S_VID_CAP,
      S_GM_ACC,
      S_GM_CAP
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_vid_pend;
   logic [ADDR_W-1:0]   r_vid_addr;
   logic [DATA_W-1:0]   r_fetch_buf;
   logic [DATA_W-1:0]   r_tile_code;
   logic                r_gm_we;
   logic [DATA_W-1:0]   r_gm_rdata;

   logic                w_trig_mid;
   logic                w_trig_eol;
   logic                w_trig;
   logic                w_load;
   logic [9:0]          w_eol_row;
   logic [ADDR_W-1:0]   w_mid_addr;
   logic [ADDR_W-1:0]   w_eol_addr;
   logic [ADDR_W-1:0]   w_trig_addr;

   // ---------------------------------------------------------------------------
   // Fetch trigger and tile load decode
   // ---------------------------------------------------------------------------
   // The mid-line trigger fetches the next tile of this row. The last visible
   // tile has no right neighbour, so the trigger stops 4 pixels before the
   // end of the visible area. The end-of-line trigger fetches column 0 of the
   // next line. On the last line it wraps to row 0.
   assign w_trig_mid = pix_ce && (hcount[TILE_BITS-1:0] == PIX_TRIG) && (hcount < H_MID_LIM);
   assign w_trig_eol = pix_ce && (hcount == H_EOL_TRIG);
   assign w_trig     = w_trig_mid || w_trig_eol;
   assign w_load     = pix_ce && ((hcount[TILE_BITS-1:0] == PIX_LAST) || (hcount == H_LAST));

   assign w_eol_row  = (vcount == V_LAST) ? 10'd0 : ((vcount + 10'd1) >> TILE_BITS);
   assign w_mid_addr = ADDR_W'(vcount >> TILE_BITS) * ADDR_W'(COLS)
                     + ADDR_W'((hcount >> TILE_BITS) + 10'd1);
   assign w_eol_addr = ADDR_W'(w_eol_row) * ADDR_W'(COLS);
   assign w_trig_addr = w_trig_eol ? w_eol_addr : w_mid_addr;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments. All registers then
   // sample the values from before the edge, whatever order the blocks run in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Video prefetch: pending flag, address, fetch buffer, displayed code
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vid_pend  <= 1'b0;
         r_vid_addr  <= '0;
         r_fetch_buf <= '0;
         r_tile_code <= '0;
      end else begin
         // A new trigger wins over the clear. If a second trigger arrives
         // before the first is served, the newer address replaces it.
         if (w_trig) begin
            r_vid_pend <= 1'b1;
            r_vid_addr <= w_trig_addr;
         end else if (r_state == S_VID_CAP) begin
            r_vid_pend <= 1'b0;
         end
         if (r_state == S_VID_CAP) begin
            r_fetch_buf <= ram_rdata;
         end
         if (w_load) begin
            r_tile_code <= r_fetch_buf;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Game side: remember the access type for the ack cycle, hold read data
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gm_we    <= 1'b0;
         r_gm_rdata <= '0;
      end else begin
         if (r_state == S_GM_ACC) begin
            r_gm_we <= gm_we;
         end
         if ((r_state == S_GM_CAP) && !r_gm_we) begin
            r_gm_rdata <= ram_rdata;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and RAM / handshake outputs
   // ---------------------------------------------------------------------------
   // The RAM port is driven from the state alone, so an asynchronous reset
   // returns it to IDLE. That drops ram_we at once and cancels any write
   // still in progress.
   // NOTE: every output gets a default before the case statement. Without
   // that, a state that skips an assignment would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      ram_addr    = '0;
      ram_we      = 1'b0;
      ram_wdata   = '0;
      gm_ack      = 1'b0;
      gm_rdata    = r_gm_rdata;

      case (r_state)
         S_IDLE: begin
            // Use the raw trigger as well, so video wins a tie with a game
            // request presented in the same clock.
            if (r_vid_pend || w_trig) begin
               w_state_nxt = S_VID_RD;
            end else if (gm_req) begin
               w_state_nxt = S_GM_ACC;
            end
         end
         S_VID_RD: begin
            ram_addr    = r_vid_addr;
            w_state_nxt = S_VID_CAP;
         end
         S_VID_CAP: begin
            // Give the port straight to a waiting game request. Going back
            // through IDLE would add a clock to the game's worst-case wait.
            if (w_trig) begin
               w_state_nxt = S_VID_RD;
            end else if (gm_req) begin
               w_state_nxt = S_GM_ACC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GM_ACC: begin
            ram_addr    = gm_addr;
            ram_we      = gm_we;
            ram_wdata   = gm_wdata;
            w_state_nxt = S_GM_CAP;
         end
         S_GM_CAP: begin
            gm_ack = 1'b1;
            if (!r_gm_we) begin
               gm_rdata = ram_rdata;
            end
            // gm_req may still be high in the ack cycle. It is deliberately
            // not taken as a new request here.
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign tile_code = r_tile_code;

`ifdef TILE_ARB_UNDERRUN_EN
   // ---------------------------------------------------------------------------
   // Sticky underrun: a tile load happened while its fetch was still pending.
   // That load shows the stale buffer contents.
   // ---------------------------------------------------------------------------
   logic r_underrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_underrun <= 1'b0;
      end else if (w_load && r_vid_pend) begin
         r_underrun <= 1'b1;
      end
   end

   assign vid_underrun = r_underrun;
`endif

endmodule

// File: tb/tb_vga_tile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_tile_arbiter
//
// Directed testbench for vga_tile_arbiter. A behavioural single-port RAM with
// one clock of read latency sits on the RAM port. Inputs change 1 time unit
// after the rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_tile_arbiter;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              pix_ce;
   logic [9:0]        hcount;
   logic [9:0]        vcount;
   logic [DATA_W-1:0] tile_code;
   logic              gm_req;
   logic              gm_we;
   logic [ADDR_W-1:0] gm_addr;
   logic [DATA_W-1:0] gm_wdata;
   logic              gm_ack;
   logic [DATA_W-1:0] gm_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
`ifdef TILE_ARB_UNDERRUN_EN
   logic              vid_underrun;
`endif

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [DATA_W-1:0] pre_data;

   int checks = 0;
   int errors = 0;

   vga_tile_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_ce    (pix_ce),
      .hcount    (hcount),
      .vcount    (vcount),
      .tile_code (tile_code),
      .gm_req    (gm_req),
      .gm_we     (gm_we),
      .gm_addr   (gm_addr),
      .gm_wdata  (gm_wdata),
      .gm_ack    (gm_ack),
      .gm_rdata  (gm_rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
`ifdef TILE_ARB_UNDERRUN_EN
      ,
      .vid_underrun (vid_underrun)
`endif
   );

   always #5 clk = ~clk;

   // Tile RAM model. The bench preload port is used only while the DUT is idle.
   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic clk_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      clk_wait(1);
      pre_we   = 1'b0;
   endtask

   // One pixel: pix_ce for one clk, then three idle clks.
   task automatic do_pixel(input logic [9:0] h, input logic [9:0] v);
      hcount = h;
      vcount = v;
      pix_ce = 1'b1;
      clk_wait(1);
      pix_ce = 1'b0;
      clk_wait(3);
   endtask

   task automatic test_reset();
      checks++;
      if ({tile_code, gm_ack, gm_rdata, ram_we, ram_addr, ram_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got tile=%0d ack=%0d rdata=%0d we=%0d addr=%0d wdata=%0d, want all 0",
                  tile_code, gm_ack, gm_rdata, ram_we, ram_addr, ram_wdata);
      end
   endtask

   // Row 1 (vcount=16), sweeping pixels 0..31. The tile for col 1 is fetched
   // at hcount=12 (address 41) and shown from hcount=16.
   task automatic test_fetch();
      logic [DATA_W-1:0] exp;
      for (int h = 0; h < 32; h++) begin
         hcount = 10'(h);
         vcount = 10'd16;
         pix_ce = 1'b1;
         @(negedge clk);
         exp = (h >= 16) ? 2'd3 : 2'd0;
         checks++;
         if (tile_code !== exp) begin
            errors++;
            $display("FAIL fetch_tile_code h=%0d: got %0d, want %0d", h, tile_code, exp);
         end
         clk_wait(1);
         pix_ce = 1'b0;
         if (h == 12) begin
            @(negedge clk);
            checks++;
            if (ram_addr !== 11'd41 || ram_we !== 1'b0) begin
               errors++;
               $display("FAIL fetch_addr: got addr=%0d we=%0d, want addr=41 we=0", ram_addr, ram_we);
            end
         end
         clk_wait(3);
      end
   endtask

   task automatic test_game_write();
      gm_req   = 1'b1;
      gm_we    = 1'b1;
      gm_addr  = 11'd100;
      gm_wdata = 2'd2;
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0 || gm_ack !== 1'b0) begin
         errors++;
         $display("FAIL gw_idle: got we=%0d ack=%0d, want 0 0", ram_we, gm_ack);
      end
      clk_wait(1);
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 11'd100 || ram_wdata !== 2'd2 || gm_ack !== 1'b0) begin
         errors++;
         $display("FAIL gw_access: got we=%0d addr=%0d wdata=%0d ack=%0d, want 1 100 2 0",
                  ram_we, ram_addr, ram_wdata, gm_ack);
      end
      clk_wait(1);
      @(negedge clk);
      checks++;
      if (gm_ack !== 1'b1 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL gw_ack: got ack=%0d we=%0d, want 1 0", gm_ack, ram_we);
      end
      clk_wait(1);
      gm_req = 1'b0;
      @(negedge clk);
      checks++;
      if (gm_ack !== 1'b0 || mem[100] !== 2'd2) begin
         errors++;
         $display("FAIL gw_result: got ack=%0d mem[100]=%0d, want 0 2", gm_ack, mem[100]);
      end
      clk_wait(1);
   endtask

   // The game read and the video trigger arrive in the same clock. Video goes
   // first and the read is acked on the fourth clock.
   task automatic test_read_vs_video();
      hcount   = 10'd28;
      vcount   = 10'd16;
      pix_ce   = 1'b1;
      gm_req   = 1'b1;
      gm_we    = 1'b0;
      gm_addr  = 11'd200;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (gm_ack !== ((c == 4) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL rv_ack c=%0d: got %0d, want %0d", c, gm_ack, (c == 4));
         end
         if (c == 1) begin
            checks++;
            if (ram_addr !== 11'd42 || ram_we !== 1'b0) begin
               errors++;
               $display("FAIL rv_vid_first: got addr=%0d we=%0d, want 42 0", ram_addr, ram_we);
            end
         end
         if (c == 3) begin
            checks++;
            if (ram_addr !== 11'd200 || ram_we !== 1'b0) begin
               errors++;
               $display("FAIL rv_gm_access: got addr=%0d we=%0d, want 200 0", ram_addr, ram_we);
            end
         end
         if (c == 4) begin
            checks++;
            if (gm_rdata !== 2'd3) begin
               errors++;
               $display("FAIL rv_rdata: got %0d, want 3", gm_rdata);
            end
         end
         clk_wait(1);
         pix_ce = 1'b0;
      end
      gm_req = 1'b0;
      @(negedge clk);
      checks++;
      if (gm_ack !== 1'b0 || gm_rdata !== 2'd3) begin
         errors++;
         $display("FAIL rv_hold: got ack=%0d rdata=%0d, want 0 3", gm_ack, gm_rdata);
      end
      clk_wait(1);
      for (int h = 29; h < 32; h++) do_pixel(10'(h), 10'd16);
      hcount = 10'd32;
      @(negedge clk);
      checks++;
      if (tile_code !== 2'd1) begin
         errors++;
         $display("FAIL rv_tile_code: got %0d, want 1", tile_code);
      end
      clk_wait(1);
   endtask

   // A write, then a read of the same tile presented right after the ack.
   task automatic test_back_to_back();
      bit got;
      int lat;
      gm_req   = 1'b1;
      gm_we    = 1'b1;
      gm_addr  = 11'd300;
      gm_wdata = 2'd1;
      for (int pass = 0; pass < 2; pass++) begin
         got = 1'b0;
         lat = 0;
         for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (gm_ack === 1'b1) begin
               got = 1'b1;
               lat = i;
            end else begin
               clk_wait(1);
            end
         end
         checks++;
         if (!got || lat != 2) begin
            errors++;
            $display("FAIL b2b_latency pass=%0d: got ack=%0d after %0d clk, want ack after 2", pass, got, lat);
         end
         checks++;
         if (gm_rdata !== ((pass == 0) ? 2'd3 : 2'd1)) begin
            errors++;
            $display("FAIL b2b_rdata pass=%0d: got %0d, want %0d", pass, gm_rdata, (pass == 0) ? 3 : 1);
         end
         clk_wait(1);
         gm_we = 1'b0;
      end
      gm_req = 1'b0;
      clk_wait(1);
   endtask

   // End-of-line fetch for column 0 of the next line, checked with and
   // without the frame wrap.
   task automatic test_line_end(input logic [9:0] v, input logic [9:0] v_next,
                                input logic [ADDR_W-1:0] exp_addr,
                                input logic [DATA_W-1:0] exp_code);
      hcount = 10'd796;
      vcount = v;
      pix_ce = 1'b1;
      clk_wait(1);
      pix_ce = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_addr !== exp_addr || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL eol_addr v=%0d: got addr=%0d we=%0d, want %0d 0", v, ram_addr, ram_we, exp_addr);
      end
      clk_wait(3);
      for (int h = 797; h < 800; h++) do_pixel(10'(h), v);
      hcount = 10'd0;
      vcount = v_next;
      @(negedge clk);
      checks++;
      if (tile_code !== exp_code) begin
         errors++;
         $display("FAIL eol_tile_code v=%0d: got %0d, want %0d", v_next, tile_code, exp_code);
      end
      clk_wait(1);
   endtask

   task automatic test_reset_mid_write();
      bit got;
      gm_req   = 1'b1;
      gm_we    = 1'b1;
      gm_addr  = 11'd500;
      gm_wdata = 2'd3;
      clk_wait(1);
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 11'd500) begin
         errors++;
         $display("FAIL rst_pre: got we=%0d addr=%0d, want 1 500", ram_we, ram_addr);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tile_code, gm_ack, gm_rdata, ram_we, ram_addr, ram_wdata} !== '0) begin
         errors++;
         $display("FAIL rst_immediate: got tile=%0d ack=%0d rdata=%0d we=%0d addr=%0d wdata=%0d, want all 0",
                  tile_code, gm_ack, gm_rdata, ram_we, ram_addr, ram_wdata);
      end
      gm_req = 1'b0;
      clk_wait(1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (gm_ack !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_ack i=%0d: got ack=%0d we=%0d, want 0 0", i, gm_ack, ram_we);
         end
         clk_wait(1);
      end
      checks++;
      if (mem[500] !== 2'd1) begin
         errors++;
         $display("FAIL rst_no_write: got mem[500]=%0d, want 1", mem[500]);
      end
      rst_n = 1'b1;
      clk_wait(1);
      gm_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (gm_ack === 1'b1) got = 1'b1;
         else clk_wait(1);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rst_reissue_ack: got no ack in 8 clk, want ack");
      end
      clk_wait(1);
      gm_req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem[500] !== 2'd3) begin
         errors++;
         $display("FAIL rst_reissue_write: got mem[500]=%0d, want 3", mem[500]);
      end
      clk_wait(1);
   endtask

`ifdef TILE_ARB_UNDERRUN_EN
   // pix_ce every clk with continuous game writes. The fetch for tile 2
   // (trigger at h=28) is still pending at the load on h=31, so the flag rises
   // from h=32 on.
   task automatic test_underrun();
      rst_n = 1'b0;
      clk_wait(1);
      checks++;
      if (vid_underrun !== 1'b0) begin
         errors++;
         $display("FAIL ur_reset: got %0d, want 0", vid_underrun);
      end
      hcount   = 10'd0;
      vcount   = 10'd0;
      pix_ce   = 1'b1;
      gm_req   = 1'b1;
      gm_we    = 1'b1;
      gm_addr  = 11'd600;
      gm_wdata = 2'd1;
      rst_n    = 1'b1;
      for (int h = 0; h < 64; h++) begin
         hcount = 10'(h);
         @(negedge clk);
         checks++;
         if (vid_underrun !== ((h >= 32) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL ur_flag h=%0d: got %0d, want %0d", h, vid_underrun, (h >= 32));
         end
         clk_wait(1);
      end
      pix_ce = 1'b0;
      gm_req = 1'b0;
      clk_wait(5);
      checks++;
      if (vid_underrun !== 1'b1) begin
         errors++;
         $display("FAIL ur_sticky: got %0d, want 1", vid_underrun);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (vid_underrun !== 1'b0) begin
         errors++;
         $display("FAIL ur_clear: got %0d, want 0", vid_underrun);
      end
      clk_wait(1);
      rst_n = 1'b1;
      clk_wait(1);
   endtask
`endif

   initial begin
      pix_ce   = 1'b0;
      hcount   = '0;
      vcount   = '0;
      gm_req   = 1'b0;
      gm_we    = 1'b0;
      gm_addr  = '0;
      gm_wdata = '0;
      pre_we   = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      #1 rst_n = 1'b0;
      #1;
      test_reset();
      preload(11'd41, 2'd3);
      preload(11'd42, 2'd1);
      preload(11'd200, 2'd3);
      preload(11'd40, 2'd3);
      preload(11'd0, 2'd2);
      preload(11'd1280, 2'd1);
      preload(11'd500, 2'd1);
      test_reset();
      rst_n = 1'b1;
      clk_wait(1);
      test_fetch();
      test_game_write();
      test_read_vs_video();
      test_back_to_back();
      test_line_end(10'd15, 10'd16, 11'd40, 2'd3);
      test_line_end(10'd524, 10'd0, 11'd0, 2'd2);
      test_reset_mid_write();
`ifdef TILE_ARB_UNDERRUN_EN
      test_underrun();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
